// File: rtl/sram_arb_ctl_pkg.sv
// sram_arb_ctl_pkg: shared constants, state encoding and lane mapping
// for the two-chip asynchronous SRAM arbiter.
package sram_arb_ctl_pkg;

    localparam int SRAM_AW   = 18;
    localparam int SRAM_DW   = 32;
    localparam int LANE_W    = 16;

    // Chip 1 carries word bits 15:0, chip 2 carries bits 31:16.
    localparam int CHIP1_LSB = 0;
    localparam int CHIP2_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_e;

    // Per-chip select and byte-lane strobes, all active low.
    typedef struct packed {
        logic ce_n;
        logic ub_n;
        logic lb_n;
    } chip_sel_t;

    localparam chip_sel_t CHIP_OFF = '{ce_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};
    localparam chip_sel_t CHIP_ALL = '{ce_n: 1'b0, ub_n: 1'b0, lb_n: 1'b0};

endpackage

// File: rtl/sram_arb_ctl.sv
// sram_arb_ctl: CPU/video arbiter and strobe sequencer for the shared SRAM pair.
// Optional build macro SRAM_BYTE_MASK_EN applies cpu_be as byte-lane masks on writes.
module sram_arb_ctl
    import sram_arb_ctl_pkg::*;
#(
    parameter int ACCESS_CYCLES  = 2,
    parameter int VID_MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [SRAM_DW-1:0] cpu_wdata,
    input  logic [3:0]         cpu_be,
    output logic               cpu_ack,
    output logic [SRAM_DW-1:0] cpu_rdata,
    input  logic               vid_req,
    input  logic [SRAM_AW-1:0] vid_addr,
    output logic               vid_ack,
    output logic [SRAM_DW-1:0] vid_rdata,
    output logic [SRAM_AW-1:0] sram_a,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_drive,
    output logic [LANE_W-1:0]  sram1_out,
    input  logic [LANE_W-1:0]  sram1_in,
    output logic               sram1_ce_n,
    output logic               sram1_ub_n,
    output logic               sram1_lb_n,
    output logic [LANE_W-1:0]  sram2_out,
    input  logic [LANE_W-1:0]  sram2_in,
    output logic               sram2_ce_n,
    output logic               sram2_ub_n,
    output logic               sram2_lb_n
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int STK_W = (VID_MAX_STREAK > 0) ? $clog2(VID_MAX_STREAK + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(VID_MAX_STREAK);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STK_W-1:0]   streak_q, streak_d;
    logic [SRAM_AW-1:0] a_q, a_d;
    logic [SRAM_DW-1:0] out_q, out_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               drive_q, drive_d;
    chip_sel_t          c1_q, c1_d;
    chip_sel_t          c2_q, c2_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               vid_ack_q, vid_ack_d;
    logic [SRAM_DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [SRAM_DW-1:0] vid_rdata_q, vid_rdata_d;

    chip_sel_t          wr_c1;
    chip_sel_t          wr_c2;
    logic [SRAM_DW-1:0] rd_word;
    logic               vid_win;

    assign rd_word = {sram2_in, sram1_in};

    // Video wins unless the CPU has waited out a full streak of video grants.
    assign vid_win = vid_req && !(cpu_req && (streak_q == STK_MAX));

    // Chip selects and byte lanes held for the whole of a CPU write.
    always_comb begin
`ifdef SRAM_BYTE_MASK_EN
        wr_c1 = '{ce_n: !(cpu_be[0] || cpu_be[1]),
                  ub_n: !cpu_be[1],
                  lb_n: !cpu_be[0]};
        wr_c2 = '{ce_n: !(cpu_be[2] || cpu_be[3]),
                  ub_n: !cpu_be[3],
                  lb_n: !cpu_be[2]};
`else
        wr_c1 = CHIP_ALL;
        wr_c2 = CHIP_ALL;
`endif
    end

`ifndef SRAM_BYTE_MASK_EN
    logic unused_be;
    assign unused_be = ^cpu_be;
`endif

    // Arbitration, access sequencing and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        a_d         = a_q;
        out_d       = out_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        drive_d     = drive_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!cpu_req) begin
                    streak_d = '0;
                end
                if (vid_win) begin
                    if (cpu_req && (streak_q != STK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                    state_d = ST_RD;
                    owner_d = OWN_VID;
                    a_d     = vid_addr;
                    cnt_d   = CNT_LOAD;
                    oe_n_d  = 1'b0;
                    we_n_d  = 1'b1;
                    drive_d = 1'b0;
                    c1_d    = CHIP_ALL;
                    c2_d    = CHIP_ALL;
                end else if (cpu_req) begin
                    streak_d = '0;
                    owner_d  = OWN_CPU;
                    a_d      = cpu_addr;
                    cnt_d    = CNT_LOAD;
                    we_n_d   = 1'b1;
                    if (cpu_wr) begin
                        state_d = ST_WR_SETUP;
                        out_d   = cpu_wdata;
                        drive_d = 1'b1;
                        oe_n_d  = 1'b1;
                        c1_d    = wr_c1;
                        c2_d    = wr_c2;
                    end else begin
                        state_d = ST_RD;
                        drive_d = 1'b0;
                        oe_n_d  = 1'b0;
                        c1_d    = CHIP_ALL;
                        c2_d    = CHIP_ALL;
                    end
                end
            end

            ST_RD: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_DONE;
                    oe_n_d  = 1'b1;
                    c1_d    = CHIP_OFF;
                    c2_d    = CHIP_OFF;
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = rd_word;
                        cpu_ack_d   = 1'b1;
                    end else begin
                        vid_rdata_d = rd_word;
                        vid_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RD_DONE: begin
                state_d = ST_IDLE;
            end

            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                we_n_d  = 1'b0;
            end

            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d   = ST_WR_HOLD;
                    we_n_d    = 1'b1;
                    cpu_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_WR_HOLD: begin
                state_d = ST_IDLE;
                drive_d = 1'b0;
                c1_d    = CHIP_OFF;
                c2_d    = CHIP_OFF;
            end

            default: begin
                state_d = ST_IDLE;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                drive_d = 1'b0;
                c1_d    = CHIP_OFF;
                c2_d    = CHIP_OFF;
            end
        endcase
    end

    // State machine and registered SRAM/requester outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            cnt_q       <= '0;
            streak_q    <= '0;
            a_q         <= '0;
            out_q       <= '0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            c1_q        <= CHIP_OFF;
            c2_q        <= CHIP_OFF;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            a_q         <= a_d;
            out_q       <= out_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rdata  = vid_rdata_q;
    assign sram_a     = a_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_drive = drive_q;
    assign sram1_out  = out_q[CHIP1_LSB +: LANE_W];
    assign sram2_out  = out_q[CHIP2_LSB +: LANE_W];
    assign sram1_ce_n = c1_q.ce_n;
    assign sram1_ub_n = c1_q.ub_n;
    assign sram1_lb_n = c1_q.lb_n;
    assign sram2_ce_n = c2_q.ce_n;
    assign sram2_ub_n = c2_q.ub_n;
    assign sram2_lb_n = c2_q.lb_n;

endmodule

// File: doc/sram_arb_ctl.md
Name: sram_arb_ctl

Overview:
Arbiter and sequencer for the board's shared asynchronous SRAM pair: two 16-bit chips on a common 18-bit address, OE_n and WE_n, presented to the design as one 32-bit word memory. Two requesters share it. The CPU memory path does reads and writes. The VGA refresh path does reads only and has priority, with a starvation bound for the CPU. The block generates all SRAM strobes and a data-drive enable for the top-level tristate.

Parameters:
ACCESS_CYCLES, 2, clock cycles that OE_n or WE_n is held active per access (min 1)
VID_MAX_STREAK, 4, consecutive video grants allowed while CPU is pending before CPU must win

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_wr  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  18  CPU word address
cpu_wdata  in  32  CPU write data
cpu_be  in  4  byte enables (used only with SRAM_BYTE_MASK_EN)
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  CPU read data, valid with cpu_ack, held until next CPU read
vid_req  in  1  video read request, level
vid_addr  in  18  video word address
vid_ack  out  1  one-cycle completion pulse
vid_rdata  out  32  video read data, valid with vid_ack, held
sram_a  out  18  SRAM address
sram_oe_n  out  1  output enable, both chips
sram_we_n  out  1  write enable, both chips
sram_drive  out  1  1 = top level drives sram1_out/sram2_out onto the I/O pins
sram1_out  out  16  write data, bits 15:0
sram1_in  in  16  read data, bits 15:0
sram1_ce_n, sram1_ub_n, sram1_lb_n  out  1 each  chip 1 select and byte lanes
sram2_out  out  16  write data, bits 31:16
sram2_in  in  16  read data, bits 31:16
sram2_ce_n, sram2_ub_n, sram2_lb_n  out  1 each  chip 2 select and byte lanes

Behaviour:
- Reset values:
  - All _n outputs = 1; sram_drive = 0; sram_a = 0; sram1_out = sram2_out = 0.
  - Acks = 0; cpu_rdata = vid_rdata = 0; state = IDLE; streak = 0.
- Reset mid-access: IDLE on the next edge, strobes deasserted, no ack issued, streak cleared.
- States: IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD. All outputs are registered.
- Arbitration in IDLE:
  - vid_req wins unless cpu_req && streak == VID_MAX_STREAK.
  - streak increments on each video grant while cpu_req is high, saturating.
  - streak clears on a CPU grant or when cpu_req is low.
- Read (either requester). Request sampled in IDLE at edge N:
  - RD occupies cycles N+1..N+ACCESS_CYCLES: sram_a = addr, ce_n = 0, oe_n = 0, ub_n = lb_n = 0, drive = 0.
  - {sram2_in, sram1_in} is captured at the end of the last RD cycle.
  - RD_DONE at cycle N+ACCESS_CYCLES+1: strobes high, ack = 1, rdata valid. Then IDLE.
  - Read latency is ACCESS_CYCLES+1 cycles from grant edge to ack.
- Write (CPU only):
  - WR_SETUP, 1 cycle: address and data valid, drive = 1, ce_n = 0, we_n = 1, oe_n = 1.
  - WR_PULSE, ACCESS_CYCLES cycles: we_n = 0.
  - WR_HOLD, 1 cycle: we_n = 1, drive = 1, data held, cpu_ack = 1. Then IDLE.
- Invariant: sram_drive and !sram_oe_n are never both true. A direct transition from write to read passes through IDLE with drive = 0, which guarantees bus turnaround.
- Requester rule: req must be low in the IDLE cycle after its ack unless it is issuing a new access. addr, wr and wdata must be stable while req is high.
- Sampling: cpu_req/vid_req are only sampled in IDLE; changes during an access are ignored. Both requesters high in IDLE is resolved by the priority rule; the loser stays pending.

Optional Feature:
SRAM_BYTE_MASK_EN
- Defined: during writes, sram1_lb_n = !cpu_be[0], sram1_ub_n = !cpu_be[1], sram2_lb_n = !cpu_be[2], sram2_ub_n = !cpu_be[3]. A chip whose two be bits are both 0 keeps ce_n = 1 for the whole write.
- Undefined: cpu_be is ignored and all four lanes are written.
- Reads always enable all lanes.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - SRAM_AW = 18 and SRAM_DW = 32;
  - lane-mapping constants (chip 1 = low half, chip 2 = high half).
- No sub-module. Arbiter logic and sequencer stay in one block; the streak counter is inline.

Test Plan:
- CPU read, addr 18'h00123, memory {16'hBEEF, 16'h1234}: oe_n low exactly 2 cycles, cpu_ack 3 cycles after grant, cpu_rdata = 32'hBEEF1234, drive stays 0.
- CPU write, addr 18'h3FFFF, data 32'hCAFEF00D: setup 1 / we_n-low 2 / hold 1 cycles, drive spans all 4, readback = 32'hCAFEF00D.
- vid_req and cpu_req both high continuously, VID_MAX_STREAK = 4: grant order V,V,V,V,C,V,V,V,V,C.
- Write then immediate read: an IDLE cycle with drive = 0 and oe_n = 1 between WR_HOLD and RD; the checker flags any overlap of drive and oe.
- Reset asserted in the 2nd WR_PULSE cycle: next cycle we_n = 1, drive = 0, no cpu_ack, state IDLE.
- With SRAM_BYTE_MASK_EN, cpu_be = 4'b0100 writing 32'h00AA0000 over 32'h11223344: readback 32'h11AA3344, sram1_ce_n = 1 throughout.
